// File: rtl/dpcm_decoder_if.sv
// Stream interface for the DPCM decoder: delta input channel, sample output channel, status.
// Latency: none, wiring only.
// Backpressure: the input side stalls on in_ready; the output side is held by out_ready.
interface dpcm_decoder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sign;
  logic             in_sof;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [15:0]      sample_count;
  logic             err_nosof;

  // Producer/consumer environment around the decoder
  modport master (
    output in_valid, in_data, in_sign, in_sof, out_ready,
    input  in_ready, out_valid, out_data, sample_count, err_nosof
  );

  // The decoder itself
  modport slave (
    input  in_valid, in_data, in_sign, in_sof, out_ready,
    output in_ready, out_valid, out_data, sample_count, err_nosof
  );
endinterface

// File: rtl/dpcm_decoder.sv
// Rebuilds samples from signed DPCM deltas (SOF word seeds the accumulator) into an output FIFO.
// Latency: one cycle from input accept to out_valid; no combinational in-to-out path.
// Backpressure: in_ready drops when the FIFO is full (registered count only); out_ready pops the head.
module dpcm_decoder #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 4,
  parameter int SATURATE = 0
) (
  input logic          clk,
  input logic          rst,
  dpcm_decoder_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [15:0]      smp_cnt_q, smp_cnt_d;
  logic             err_q, err_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             in_rdy;
  logic             out_vld;
  logic             accept;
  logic             pop;
  logic             push;
  logic [WIDTH-1:0] push_dat;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;
  logic [WIDTH-1:0] next_acc;

  // DEPTH is a power of two, so the count MSB alone flags a full FIFO
  assign in_rdy  = ~count_q[AW];
  assign out_vld = |count_q;
  assign accept  = bus.in_valid & in_rdy;
  assign pop     = out_vld & bus.out_ready;

  assign bus.in_ready     = in_rdy;
  assign bus.out_valid    = out_vld;
  assign bus.out_data     = out_vld ? mem_q[rd_ptr_q] : '0;
  assign bus.sample_count = smp_cnt_q;
  assign bus.err_nosof    = err_q;

  // One extra bit on both operands exposes add carry-out and subtract borrow
  assign sum_w  = {1'b0, acc_q} + {1'b0, bus.in_data};
  assign diff_w = {1'b0, acc_q} - {1'b0, bus.in_data};

  // Next accumulator value from a delta, wrapping or clamping at the range ends
  always_comb begin
    next_acc = sum_w[WIDTH-1:0];
    if (bus.in_sign) begin
      if ((SATURATE != 0) && diff_w[WIDTH]) begin
        next_acc = '0;
      end else begin
        next_acc = diff_w[WIDTH-1:0];
      end
    end else begin
      if ((SATURATE != 0) && sum_w[WIDTH]) begin
        next_acc = '1;
      end else begin
        next_acc = sum_w[WIDTH-1:0];
      end
    end
  end

  // Frame state, accumulator, sample counter and the no-SOF error flag
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    smp_cnt_d = smp_cnt_q;
    err_d     = err_q;
    push      = 1'b0;
    push_dat  = next_acc;
    if (accept) begin
      if (bus.in_sof) begin
        acc_d     = bus.in_data;
        push_dat  = bus.in_data;
        push      = 1'b1;
        smp_cnt_d = 16'd1;
        state_d   = ST_RUN;
      end else if (state_q == ST_RUN) begin
        acc_d     = next_acc;
        push      = 1'b1;
        smp_cnt_d = smp_cnt_q + 16'd1;
      end else begin
        // No reference sample yet: the delta is consumed and dropped
        err_d = 1'b1;
      end
    end
  end

  // FIFO pointer and occupancy update; pointers wrap naturally at DEPTH
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control and status registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      smp_cnt_q <= '0;
      err_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      smp_cnt_q <= smp_cnt_d;
      err_q     <= err_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // FIFO storage; contents become unreachable on reset because the pointers clear
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_dat;
    end
  end

endmodule

// File: tb/tb_dpcm_decoder.sv
// Directed bench for dpcm_decoder: a wrapping and a saturating instance share one stimulus stream.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: out_ready is driven per test to exercise full/empty and simultaneous push/pop.
module tb_dpcm_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_sign;
  logic        in_sof;
  logic        out_ready;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dpcm_decoder_if #(.WIDTH(32)) bw ();
  dpcm_decoder_if #(.WIDTH(32)) bs ();

  assign bw.in_valid  = in_valid;
  assign bw.in_data   = in_data;
  assign bw.in_sign   = in_sign;
  assign bw.in_sof    = in_sof;
  assign bw.out_ready = out_ready;
  assign bs.in_valid  = in_valid;
  assign bs.in_data   = in_data;
  assign bs.in_sign   = in_sign;
  assign bs.in_sof    = in_sof;
  assign bs.out_ready = out_ready;

  dpcm_decoder #(.WIDTH(32), .DEPTH(4), .SATURATE(0)) u_wrap (
    .clk (clk),
    .rst (rst),
    .bus (bw.slave)
  );

  dpcm_decoder #(.WIDTH(32), .DEPTH(4), .SATURATE(1)) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (bs.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Offer one word and wait (bounded) until the decoder takes it
  task automatic send(input logic sof, input logic sign, input logic [31:0] d);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_sof   = sof;
    in_sign  = sign;
    in_data  = d;
    while (!bw.in_ready && n < 50) begin
      tick();
      n++;
    end
    check("send_in_ready", 32'(bw.in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sign   = 1'b0;
    in_sof    = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();

    // Test 1: reset state, then SOF 100, +5, -3 streaming
    do_reset();
    check("rst_out_valid", 32'(bw.out_valid), 32'd0);
    check("rst_in_ready", 32'(bw.in_ready), 32'd1);
    check("rst_out_data", bw.out_data, 32'd0);
    check("rst_sample_count", 32'(bw.sample_count), 32'd0);
    check("rst_err_nosof", 32'(bw.err_nosof), 32'd0);
    out_ready = 1'b1;
    send(1'b1, 1'b0, 32'd100);
    check("t1_out0_valid", 32'(bw.out_valid), 32'd1);
    check("t1_out0", bw.out_data, 32'd100);
    send(1'b0, 1'b0, 32'd5);
    check("t1_out1", bw.out_data, 32'd105);
    send(1'b0, 1'b1, 32'd3);
    check("t1_out2", bw.out_data, 32'd102);
    check("t1_sample_count", 32'(bw.sample_count), 32'd3);
    check("t1_err_nosof", 32'(bw.err_nosof), 32'd0);
    tick();
    check("t1_drained", 32'(bw.out_valid), 32'd0);

    // Test 2: delta without SOF is dropped and flags the error
    do_reset();
    send(1'b0, 1'b0, 32'd7);
    check("t2_no_push", 32'(bw.out_valid), 32'd0);
    check("t2_err_set", 32'(bw.err_nosof), 32'd1);
    check("t2_count_zero", 32'(bw.sample_count), 32'd0);
    send(1'b1, 1'b0, 32'd10);
    check("t2_sof_valid", 32'(bw.out_valid), 32'd1);
    check("t2_sof_data", bw.out_data, 32'd10);
    check("t2_err_sticky", 32'(bw.err_nosof), 32'd1);
    tick();

    // Test 3: fill to DEPTH with out_ready low, fifth word held, then drain
    do_reset();
    out_ready = 1'b0;
    send(1'b1, 1'b0, 32'd1);
    send(1'b0, 1'b0, 32'd1);
    send(1'b0, 1'b0, 32'd1);
    send(1'b0, 1'b0, 32'd1);
    check("t3_full_in_ready", 32'(bw.in_ready), 32'd0);
    check("t3_head", bw.out_data, 32'd1);
    in_valid = 1'b1;
    in_sof   = 1'b0;
    in_sign  = 1'b0;
    in_data  = 32'd1;
    tick();
    check("t3_held_in_ready", 32'(bw.in_ready), 32'd0);
    check("t3_head_stable", bw.out_data, 32'd1);
    check("t3_count_4", 32'(bw.sample_count), 32'd4);
    out_ready = 1'b1;
    tick();
    check("t3_pop1_next", bw.out_data, 32'd2);
    check("t3_in_ready_back", 32'(bw.in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("t3_pop2_next", bw.out_data, 32'd3);
    check("t3_count_5", 32'(bw.sample_count), 32'd5);
    tick();
    check("t3_pop3_next", bw.out_data, 32'd4);
    tick();
    check("t3_pop4_next", bw.out_data, 32'd5);
    tick();
    check("t3_empty", 32'(bw.out_valid), 32'd0);

    // Test 4: wrap versus saturate at both ends of the range
    do_reset();
    out_ready = 1'b1;
    send(1'b1, 1'b0, 32'hFFFF_FFFF);
    check("t4_seed_wrap", bw.out_data, 32'hFFFF_FFFF);
    check("t4_seed_sat", bs.out_data, 32'hFFFF_FFFF);
    send(1'b0, 1'b0, 32'd2);
    check("t4_add_wrap", bw.out_data, 32'h0000_0001);
    check("t4_add_sat", bs.out_data, 32'hFFFF_FFFF);
    send(1'b1, 1'b0, 32'd1);
    check("t4_seed1", bw.out_data, 32'd1);
    send(1'b0, 1'b1, 32'd3);
    check("t4_sub_wrap", bw.out_data, 32'hFFFF_FFFE);
    check("t4_sub_sat", bs.out_data, 32'h0000_0000);
    send(1'b0, 1'b0, 32'd1);
    check("t4_after_wrap", bw.out_data, 32'hFFFF_FFFF);
    check("t4_after_sat", bs.out_data, 32'h0000_0001);
    tick();

    // Test 5: mid-stream SOF reseeds, then push+pop at occupancy 2
    do_reset();
    out_ready = 1'b1;
    send(1'b1, 1'b0, 32'd200);
    check("t5_s0", bw.out_data, 32'd200);
    send(1'b0, 1'b0, 32'd10);
    check("t5_s1", bw.out_data, 32'd210);
    send(1'b1, 1'b0, 32'd500);
    check("t5_s2", bw.out_data, 32'd500);
    check("t5_cnt_after_sof", 32'(bw.sample_count), 32'd1);
    send(1'b0, 1'b1, 32'd1);
    check("t5_s3", bw.out_data, 32'd499);
    check("t5_cnt_end", 32'(bw.sample_count), 32'd2);
    out_ready = 1'b0;
    send(1'b0, 1'b0, 32'd1);
    check("t5_head_499", bw.out_data, 32'd499);
    out_ready = 1'b1;
    send(1'b0, 1'b0, 32'd1);
    check("t5_pushpop_head", bw.out_data, 32'd500);
    tick();
    check("t5_second_valid", 32'(bw.out_valid), 32'd1);
    check("t5_second_data", bw.out_data, 32'd501);
    tick();
    check("t5_drained", 32'(bw.out_valid), 32'd0);

    // Test 6: reset with samples buffered discards them
    do_reset();
    out_ready = 1'b0;
    send(1'b1, 1'b0, 32'd7);
    send(1'b0, 1'b0, 32'd1);
    send(1'b0, 1'b0, 32'd1);
    check("t6_buffered", 32'(bw.out_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_valid", 32'(bw.out_valid), 32'd0);
    check("t6_rst_in_ready", 32'(bw.in_ready), 32'd1);
    check("t6_rst_data", bw.out_data, 32'd0);
    check("t6_rst_count", 32'(bw.sample_count), 32'd0);
    send(1'b0, 1'b0, 32'd4);
    check("t6_delta_dropped", 32'(bw.out_valid), 32'd0);
    check("t6_err_set", 32'(bw.err_nosof), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dpcm_decoder.md
Name: dpcm_decoder

Overview:
Reconstructs a sample stream from signed DPCM deltas. It is the receive-side counterpart of the team's DPCM difference encoder, which emits the magnitude of consecutive-word differences; here each delta also carries a sign bit. A start-of-frame word seeds the accumulator with an absolute value, and subsequent deltas are added or subtracted from it. Reconstructed samples are queued in a small output FIFO with valid/ready handshakes on both sides.

Parameters:
WIDTH, 32, sample and delta width in bits
DEPTH, 4, output FIFO depth in entries; power of two, >= 2
SATURATE, 0, 0 = modulo-2^WIDTH wrap; 1 = clamp to 0 / 2^WIDTH-1

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  input word present
in_ready  output  1  decoder can accept the input word this cycle
in_data  input  WIDTH  delta magnitude, or absolute seed when in_sof=1
in_sign  input  1  0 = add delta, 1 = subtract delta; ignored when in_sof=1
in_sof  input  1  start of frame; in_data is the absolute seed sample
out_valid  output  1  reconstructed sample available
out_ready  input  1  downstream accepts the sample
out_data  output  WIDTH  reconstructed sample (unsigned)
sample_count  output  16  samples produced since the last accepted SOF
err_nosof  output  1  sticky: a delta arrived before any SOF

Behaviour:
- Reset: acc=0, state=IDLE, FIFO count=0 with pointers at 0, out_valid=0, in_ready=1, out_data=0, sample_count=0, err_nosof=0.
- Reset mid-operation discards all FIFO contents and the accumulator.
- Handshakes:
  - Input accept = in_valid & in_ready. Output pop = out_valid & out_ready.
  - in_ready = (count < DEPTH). It depends only on registered count. A full FIFO blocks input even if a pop occurs in the same cycle.
  - out_valid = (count != 0). out_data = FIFO head when valid, 0 otherwise.
  - out_data is held stable while out_valid=1 and out_ready=0.
- States: IDLE (no reference sample) and RUN.
  - Accepted word with in_sof=1 (any state): acc <= in_data; push in_data; sample_count <= 1; state <= RUN.
  - Accepted word with in_sof=0 in RUN: compute next = acc + in_data (in_sign=0) or acc - in_data (in_sign=1); acc <= next; push next; sample_count <= sample_count+1, wrapping 65535 -> 0.
  - Accepted word with in_sof=0 in IDLE: word is consumed and dropped, nothing is pushed, err_nosof <= 1, state stays IDLE.
- Arithmetic is unsigned, WIDTH bits.
  - SATURATE=0: result is modulo 2^WIDTH.
  - SATURATE=1: add carry-out gives all-ones; subtract borrow gives 0; acc takes the clamped value.
- Latency: a word accepted in cycle N into an empty FIFO gives out_valid=1 in cycle N+1 with that sample. There is no combinational in-to-out path.
- Simultaneous push and pop: count unchanged, both pointers advance. Pointers wrap modulo DEPTH.
- Ordering: strict FIFO; no sample is dropped or duplicated under any out_ready pattern.
- err_nosof is cleared only by rst.

Test Plan:
1. After rst, send SOF 100, then (+,5), then (-,3) with out_ready=1 -> out_data 100, 105, 102 on consecutive cycles starting one cycle after the first accept; sample_count=3; err_nosof=0.
2. After rst, send delta (+,7) without SOF -> word consumed, out_valid stays 0, err_nosof=1. Then SOF 10 -> out_data 10; err_nosof remains 1.
3. DEPTH=4, out_ready=0, offer SOF 1 then +1 four times -> in_ready=0 after 4 accepts and the fifth word is held. Raise out_ready -> outputs 1, 2, 3, 4, 5 in order; in_ready reasserts the cycle after the first pop.
4. Wrap vs saturate:
   - SOF 0xFFFFFFFF, then (+,2) -> 0x00000001 with SATURATE=0, 0xFFFFFFFF with SATURATE=1.
   - SOF 1, then (-,3) -> 0xFFFFFFFE with SATURATE=0, 0x00000000 with SATURATE=1.
5. Mid-stream SOF: SOF 200, (+,10), SOF 500, (-,1) -> 200, 210, 500, 499. sample_count reads 1 after the second SOF and 2 at the end. Also check that a simultaneous push/pop at count=2 leaves count=2.
6. With 3 samples buffered, assert rst for one cycle -> out_valid=0 and in_ready=1 the next cycle. A following non-SOF delta is dropped and sets err_nosof=1.
